// File: rtl/rsign_para_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rsign_para_loader
//  Purpose  : Loads a bank of FM_DEPTH signed per-channel thresholds from a
//             serial valid/ready stream (channel 0 first). It then switches
//             the sign datapath into calculate mode. While the bank is being
//             (re)loaded, the upstream data-enable is blocked.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, rising edge
//    rst_n       in   asynchronous active-low reset
//    load_req    in   request to (re)load the whole threshold bank
//    para_valid  in   para_in carries a threshold
//    para_in     in   serial signed threshold, PARA_WIDTH bits
//    para_ready  out  threshold accepted this cycle (high only in LOAD)
//    data_e_in   in   upstream data-enable
//    data_e_out  out  data_e_in delayed one cycle, passed only if sampled in CALC
//    mode        out  0 = reload parameters, 1 = calculate (registered)
//    para_out    out  threshold bank; channel i occupies
//                     [i*PARA_WIDTH +: PARA_WIDTH], two's complement
//    load_done   out  one-cycle pulse in the first CALC cycle after a load
//    busy        out  high while in LOAD
// ============================================================================
module rsign_para_loader #(
   parameter int FM_DEPTH   = 256,
   parameter int PARA_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load_req,
   input  logic                           para_valid,
   input  logic signed [PARA_WIDTH-1:0]   para_in,
   output logic                           para_ready,
   input  logic                           data_e_in,
   output logic                           data_e_out,
   output logic                           mode,
   output logic [FM_DEPTH*PARA_WIDTH-1:0] para_out,
   output logic                           load_done,
   output logic                           busy
);

   // The channel counter is at least one bit wide, even when FM_DEPTH == 1.
   localparam int              CNT_W    = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FM_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic             last_beat;

   // A beat is accepted only in LOAD. Because para_ready is high for the
   // whole LOAD state, para_valid alone qualifies the beat there.
   always_comb begin
      accept    = (state == LOAD) && para_valid;
      last_beat = accept && (cnt == LAST_CNT);
   end

   assign para_ready = (state == LOAD);
   assign busy       = (state == LOAD);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state and counter update
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (load_req) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         LOAD: begin
            // load_req is deliberately ignored here: a load in progress
            // always runs to completion.
            if (accept) begin
               if (last_beat) begin
                  state_nxt = CALC;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         CALC: begin
            if (load_req) begin
               state_nxt = LOAD;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Counter and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         mode       <= 1'b0;
         load_done  <= 1'b0;
         data_e_out <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         // mode follows the state it is entering, so it is 1 exactly in CALC.
         mode       <= (state_nxt == CALC);
         load_done  <= last_beat;
         // Gate with the state at sampling time. A beat that arrives together
         // with a reload request in CALC still passes through.
         data_e_out <= data_e_in && (state == CALC);
      end
   end

   // ---------------------------------------------------------------------
   // Threshold bank: one register per channel. Each register is written only
   // by the accepted beat that addresses it, so old values persist until they
   // are overwritten.
   // ---------------------------------------------------------------------
   for (genvar i = 0; i < FM_DEPTH; i++) begin : g_bank
      logic [PARA_WIDTH-1:0] entry;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry <= '0;
         end else if (accept && (cnt == CNT_W'(i))) begin
            entry <= para_in;
         end
      end

      assign para_out[i*PARA_WIDTH +: PARA_WIDTH] = entry;
   end

endmodule
`default_nettype wire

// File: tb/tb_rsign_para_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsign_para_loader
//  Purpose  : Directed, table-driven bench for rsign_para_loader with
//             FM_DEPTH = 4 and PARA_WIDTH = 16. Hand-written sequences cover
//             reset in the middle of a load and a reload with load_req held.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rsign_para_loader;

   localparam int D = 4;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_req = 1'b0;
   logic          para_valid = 1'b0;
   logic [W-1:0]  para_in = '0;
   logic          para_ready;
   logic          data_e_in = 1'b0;
   logic          data_e_out;
   logic          mode;
   logic [D*W-1:0] para_out;
   logic          load_done;
   logic          busy;

   int tests = 0;
   int fails = 0;

   rsign_para_loader #(.FM_DEPTH(D), .PARA_WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_req   (load_req),
      .para_valid (para_valid),
      .para_in    (para_in),
      .para_ready (para_ready),
      .data_e_in  (data_e_in),
      .data_e_out (data_e_out),
      .mode       (mode),
      .para_out   (para_out),
      .load_done  (load_done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        lr;
      logic        pv;
      logic [15:0] pin;
      logic        dei;
      logic        rdy;
      logic        bsy;
      logic        md;
      logic        done;
      logic        deo;
      logic [63:0] bank;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   // Packs four channel values with channel 0 in the least significant bits.
   function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
      logic [15:0] sa, sb, sc, sd;
      sa = a[15:0];
      sb = b[15:0];
      sc = c[15:0];
      sd = d[15:0];
      return {sd, sc, sb, sa};
   endfunction

   function automatic vec_t mk(input logic lr, input logic pv, input int pin, input logic dei,
                               input logic rdy, input logic bsy, input logic md,
                               input logic done, input logic deo, input logic [63:0] bank);
      vec_t v;
      v.lr   = lr;
      v.pv   = pv;
      v.pin  = pin[15:0];
      v.dei  = dei;
      v.rdy  = rdy;
      v.bsy  = bsy;
      v.md   = md;
      v.done = done;
      v.deo  = deo;
      v.bank = bank;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic rdy, input logic bsy, input logic md,
                          input logic done, input logic deo, input logic [63:0] bank);
      chk("para_ready", idx, {63'd0, para_ready}, {63'd0, rdy});
      chk("busy",       idx, {63'd0, busy},       {63'd0, bsy});
      chk("mode",       idx, {63'd0, mode},       {63'd0, md});
      chk("load_done",  idx, {63'd0, load_done},  {63'd0, done});
      chk("data_e_out", idx, {63'd0, data_e_out}, {63'd0, deo});
      chk("para_out",   idx, para_out, bank);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic lr, input logic pv, input int pin, input logic dei);
      load_req   = lr;
      para_valid = pv;
      para_in    = pin[15:0];
      data_e_in  = dei;
   endtask

   initial begin
      logic [63:0] b1, b2;
      int          done_cnt;
      int          done_at;

      b1 = pk(5, -3, 7, 0);
      b2 = pk(-1, 2, -32768, 12345);

      //               lr  pv  pin     dei   rdy bsy md dn deo bank
      // IDLE: data enable and parameter beats are both ignored.
      vecs[0]  = mk(0, 0, 0,      1,    0, 0, 0, 0, 0, 64'd0);
      vecs[1]  = mk(0, 1, 9,      1,    0, 0, 0, 0, 0, 64'd0);
      vecs[2]  = mk(1, 0, 0,      1,    1, 1, 0, 0, 0, 64'd0);
      // LOAD, with load_req repeated; includes one stall cycle.
      vecs[3]  = mk(1, 1, 5,      0,    1, 1, 0, 0, 0, pk(5, 0, 0, 0));
      vecs[4]  = mk(1, 1, -3,     0,    1, 1, 0, 0, 0, pk(5, -3, 0, 0));
      vecs[5]  = mk(1, 0, 100,    0,    1, 1, 0, 0, 0, pk(5, -3, 0, 0));
      vecs[6]  = mk(0, 1, 7,      0,    1, 1, 0, 0, 0, pk(5, -3, 7, 0));
      vecs[7]  = mk(0, 1, 0,      0,    0, 0, 1, 1, 0, b1);
      // CALC: three data-enable beats, delayed by one cycle.
      vecs[8]  = mk(0, 0, 0,      1,    0, 0, 1, 0, 1, b1);
      vecs[9]  = mk(0, 0, 0,      1,    0, 0, 1, 0, 1, b1);
      vecs[10] = mk(0, 0, 0,      1,    0, 0, 1, 0, 1, b1);
      vecs[11] = mk(0, 0, 0,      0,    0, 0, 1, 0, 0, b1);
      vecs[12] = mk(0, 1, 55,     0,    0, 0, 1, 0, 0, b1);
      // Reload from CALC with data_e_in held: one trailing beat, then blocked.
      vecs[13] = mk(1, 0, 0,      1,    1, 1, 0, 0, 1, b1);
      vecs[14] = mk(0, 1, -1,     1,    1, 1, 0, 0, 0, pk(-1, -3, 7, 0));
      vecs[15] = mk(0, 0, 0,      1,    1, 1, 0, 0, 0, pk(-1, -3, 7, 0));
      vecs[16] = mk(0, 0, 0,      0,    1, 1, 0, 0, 0, pk(-1, -3, 7, 0));
      vecs[17] = mk(0, 1, 2,      0,    1, 1, 0, 0, 0, pk(-1, 2, 7, 0));
      vecs[18] = mk(0, 0, 0,      0,    1, 1, 0, 0, 0, pk(-1, 2, 7, 0));
      vecs[19] = mk(0, 0, 0,      0,    1, 1, 0, 0, 0, pk(-1, 2, 7, 0));
      vecs[20] = mk(0, 1, -32768, 0,    1, 1, 0, 0, 0, pk(-1, 2, -32768, 0));
      vecs[21] = mk(0, 0, 0,      0,    1, 1, 0, 0, 0, pk(-1, 2, -32768, 0));
      vecs[22] = mk(0, 0, 0,      0,    1, 1, 0, 0, 0, pk(-1, 2, -32768, 0));
      vecs[23] = mk(0, 1, 12345,  0,    0, 0, 1, 1, 0, b2);
      vecs[24] = mk(0, 0, 0,      0,    0, 0, 1, 0, 0, b2);

      // Reset state, checked before any clock edge.
      #2;
      chk_all(-1, 0, 0, 0, 0, 0, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].lr, vecs[i].pv, vecs[i].pin, vecs[i].dei);
         step();
         chk_all(i, vecs[i].rdy, vecs[i].bsy, vecs[i].md, vecs[i].done, vecs[i].deo, vecs[i].bank);
      end

      // Reset in the middle of a load, after 2 of 4 beats.
      drive(1, 0, 0, 1);
      step();
      drive(0, 1, 11, 1);
      step();
      drive(0, 1, 22, 1);
      step();
      chk("partial_bank", 100, para_out, pk(11, 22, -32768, 12345));
      drive(0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(101, 0, 0, 0, 0, 0, 64'd0);
      step();
      step();
      rst_n = 1'b1;
      // After release, para_valid without load_req is ignored.
      drive(0, 1, 77, 0);
      step();
      chk_all(102, 0, 0, 0, 0, 0, 64'd0);
      step();
      chk_all(103, 0, 0, 0, 0, 0, 64'd0);

      // Fresh load with load_req held throughout; count load_done pulses.
      drive(1, 0, 0, 0);
      step();
      chk_all(104, 1, 1, 0, 0, 0, 64'd0);
      done_cnt = 0;
      done_at  = -1;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) drive(1, 1, k + 1, 0);
         else       drive(0, 0, 0, 0);
         step();
         if (load_done) begin
            done_cnt++;
            done_at = k;
         end
      end
      chk("done_count", 105, 64'(done_cnt), 64'd1);
      chk("done_cycle", 106, 64'(done_at), 64'd3);
      chk_all(107, 0, 0, 1, 0, 0, pk(1, 2, 3, 4));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Watchdog so the run always ends, even if something above stalls.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000 ns");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/rsign_para_loader.md
RSIGN_PARA_LOADER -- requirements
Module: rsign_para_loader

Interface
REQ-001 The block SHALL have parameter FM_DEPTH, default 256, meaning the number of per-channel thresholds held.
REQ-002 The block SHALL have parameter PARA_WIDTH, default 16, meaning the width of one signed threshold.
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port load_req  input  1  request to (re)load the full threshold bank.
REQ-006 The block SHALL have port para_valid  input  1  para_in carries a threshold.
REQ-007 The block SHALL have port para_in  input  PARA_WIDTH signed  serial threshold, channel 0 first.
REQ-008 The block SHALL have port para_ready  output  1  block accepts para_in this cycle.
REQ-009 The block SHALL have port data_e_in  input  1  upstream data-enable.
REQ-010 The block SHALL have port data_e_out  output  1  gated data-enable to the sign datapath.
REQ-011 The block SHALL have port mode  output  1  0 = reload parameter, 1 = calculate.
REQ-012 The block SHALL have port para_out  output  FM_DEPTH x PARA_WIDTH signed  threshold bank.
REQ-013 The block SHALL have port load_done  output  1  one-cycle pulse when the bank is complete.
REQ-014 The block SHALL have port busy  output  1  high while in LOAD.

Function
REQ-015 The block SHALL implement FSM states IDLE, LOAD, CALC; reset state IDLE.
REQ-016 In IDLE, load_req=1 SHALL move the FSM to LOAD next cycle with the channel counter cleared to 0.
REQ-017 In LOAD, para_ready SHALL be 1, and busy SHALL be 1.
REQ-018 In LOAD, a cycle with para_valid=1 and para_ready=1 SHALL write para_in to para_out[cnt] and increment cnt.
REQ-019 para_valid=0 in LOAD SHALL hold cnt and the bank unchanged (stall, no timeout).
REQ-020 The accepted beat with cnt=FM_DEPTH-1 SHALL move the FSM to CALC next cycle, reset cnt to 0, and pulse load_done for exactly that next cycle.
REQ-021 load_req during LOAD SHALL be ignored; the load SHALL not restart.
REQ-022 In CALC, load_req=1 SHALL move the FSM to LOAD next cycle, clear cnt, and drop mode to 0 that cycle; existing para_out values SHALL persist until overwritten.
REQ-023 mode SHALL be registered: 1 exactly in the cycles the FSM is in CALC, else 0.
REQ-024 data_e_out SHALL be data_e_in registered by one cycle, AND-ed with the FSM being in CALC in the cycle data_e_in was sampled.
REQ-025 data_e_in sampled in the same cycle as load_req in CALC SHALL still propagate (FSM was CALC when sampled); subsequent beats SHALL be blocked.
REQ-026 para_ready SHALL be 0 in IDLE and CALC; para_valid there SHALL be ignored.
REQ-027 cnt SHALL be ceil(log2(FM_DEPTH)) bits wide (minimum 1) and SHALL never exceed FM_DEPTH-1.
REQ-028 para_out entries SHALL change only on accepted LOAD beats.

Reset
REQ-029 On rst_n=0, asynchronously: FSM=IDLE, cnt=0, mode=0, data_e_out=0, load_done=0, busy=0, para_ready=0, every para_out entry=0.
REQ-030 Reset asserted mid-LOAD SHALL abandon the load; after release the FSM SHALL be IDLE and a new load_req SHALL be required.

Verification
REQ-031 FM_DEPTH=4: reset, load_req, stream 5,-3,7,0 back-to-back -> para_out={5,-3,7,0}, load_done one pulse, mode=1 from the next cycle.
REQ-032 Same load with para_valid gaps of 2 cycles between beats -> identical bank, cnt held during gaps, load_done only after 4th beat.
REQ-033 In CALC, data_e_in=1 for 3 cycles -> data_e_out=1 for 3 cycles delayed by one; in IDLE the same stimulus -> data_e_out stays 0.
REQ-034 In CALC, load_req with data_e_in=1 held -> one trailing data_e_out beat, then 0; mode=0; old bank visible until new beats overwrite channel by channel.
REQ-035 Reset asserted after 2 of 4 beats -> all outputs 0, bank 0, FSM IDLE; para_valid without load_req -> para_ready stays 0, bank unchanged.
REQ-036 load_req pulsed repeatedly during LOAD -> cnt progression unaffected, single load_done.
